// File: rtl/fft_mag_peak_if.sv
// Handshake and result bus between the FFT core, the magnitude/peak stage and the SPI output stage.
interface fft_mag_peak_if #(
  parameter int N   = 32,
  parameter int MSB = 16
);
  logic                   start;
  logic [N*MSB-1:0]       data_bus;
  logic                   busy;
  logic                   done;
  logic [N*MSB-1:0]       mag_bus;
  logic [$clog2(N)-1:0]   peak_bin;
  logic [MSB/2:0]         peak_mag;

  modport master (
    output start, data_bus,
    input  busy, done, mag_bus, peak_bin, peak_mag
  );

  modport slave (
    input  start, data_bus,
    output busy, done, mag_bus, peak_bin, peak_mag
  );
endinterface

// File: rtl/fft_mag_peak.sv
// Post-FFT magnitude and lower-half peak search, one bin per clock through a 2-stage pipeline.
// Define FFT_MAG_ALPHA_BETA_EN for alpha-max-beta-min magnitude; default is the L1 norm.
module fft_mag_peak #(
  parameter int N   = 32,
  parameter int MSB = 16
) (
  input  logic          clk,
  input  logic          rst,
  fft_mag_peak_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int HALF  = MSB / 2;
  localparam int MAG_W = HALF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Two's-complement absolute value; the most negative code maps to 2^(HALF-1) unsigned.
  function automatic logic [HALF-1:0] abs_f(input logic [HALF-1:0] v);
    logic [HALF-1:0] r;
    if (v[HALF-1]) begin
      r = ~v + HALF'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [MAG_W-1:0] mag_f(input logic [HALF-1:0] ra, input logic [HALF-1:0] ia);
    logic [MAG_W-1:0] m;
`ifdef FFT_MAG_ALPHA_BETA_EN
    logic [HALF-1:0] mx;
    logic [HALF-1:0] mn;
    if (ra >= ia) begin
      mx = ra;
      mn = ia;
    end else begin
      mx = ia;
      mn = ra;
    end
    m = {1'b0, mx} + {2'b00, mn[HALF-1:1]};
`else
    m = {1'b0, ra} + {1'b0, ia};
`endif
    return m;
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic [N*MSB-1:0]   frame_r;
  logic [IDX_W-1:0]   idx_r;
  logic               capture_s;
  logic               issue_s;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic               busy_r;
  logic               done_r;
  logic [MSB-1:0]     word_s;
  logic [HALF-1:0]    s1_ra_r;
  logic [HALF-1:0]    s1_ia_r;
  logic [IDX_W-1:0]   s1_idx_r;
  logic               s1_valid_r;
  logic               s1_last_r;
  logic               s2_last_r;
  logic [MAG_W-1:0]   mag_s;
  logic [N*MSB-1:0]   mag_bus_r;
  logic [IDX_W-1:0]   peak_bin_r;
  logic [MAG_W-1:0]   peak_mag_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; FLUSH lasts until the last bin has left stage 2.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (idx_r == IDX_W'(N - 1)) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = CALC;
        end
      end
      FLUSH: begin
        if (s2_last_r) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = FLUSH;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output/control decode; busy and done are registered from these next values.
  always_comb begin
    capture_s  = 1'b0;
    issue_s    = 1'b0;
    done_nxt_s = 1'b0;
    case (state_r)
      IDLE:    capture_s  = bus.start;
      CALC:    issue_s    = 1'b1;
      FLUSH:   done_nxt_s = s2_last_r;
      default: capture_s  = 1'b0;
    endcase
    busy_nxt_s = (next_state_s != IDLE);
  end

  always_comb begin
    word_s = frame_r[int'(idx_r)*MSB +: MSB];
    mag_s  = mag_f(s1_ra_r, s1_ia_r);
  end

  // Capture, stage 1 (absolute values), stage 2 (magnitude write-back and peak update).
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_r    <= '0;
      idx_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      s1_ra_r    <= '0;
      s1_ia_r    <= '0;
      s1_idx_r   <= '0;
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s2_last_r  <= 1'b0;
      mag_bus_r  <= '0;
      peak_bin_r <= '0;
      peak_mag_r <= '0;
    end else begin
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      s1_valid_r <= issue_s;
      s1_last_r  <= issue_s && (idx_r == IDX_W'(N - 1));
      s2_last_r  <= s1_last_r;
      if (capture_s) begin
        frame_r    <= bus.data_bus;
        idx_r      <= '0;
        peak_bin_r <= '0;
        peak_mag_r <= '0;
      end else if (issue_s) begin
        idx_r    <= idx_r + IDX_W'(1);
        s1_ra_r  <= abs_f(word_s[MSB-1:HALF]);
        s1_ia_r  <= abs_f(word_s[HALF-1:0]);
        s1_idx_r <= idx_r;
      end
      // Strict compare so ties keep the lower bin; only the lower half-spectrum competes.
      if (s1_valid_r) begin
        mag_bus_r[int'(s1_idx_r)*MSB +: MSB] <= {{(MSB-MAG_W){1'b0}}, mag_s};
        if ((s1_idx_r < IDX_W'(N / 2)) && (mag_s > peak_mag_r)) begin
          peak_bin_r <= s1_idx_r;
          peak_mag_r <= mag_s;
        end
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.mag_bus  = mag_bus_r;
  assign bus.peak_bin = peak_bin_r;
  assign bus.peak_mag = peak_mag_r;
endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak: cycle-count model of busy/done plus integer-arithmetic results.
module tb_fft_mag_peak;
  localparam int N   = 32;
  localparam int MSB = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fft_mag_peak_if #(.N(N), .MSB(MSB)) ifc ();
  fft_mag_peak #(.N(N), .MSB(MSB)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*MSB-1:0] act, input logic [N*MSB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mag_of(input logic [15:0] w);
    int re, im, ra, ia;
    re = int'($signed(w[15:8]));
    im = int'($signed(w[7:0]));
    ra = (re < 0) ? -re : re;
    ia = (im < 0) ? -im : im;
`ifdef FFT_MAG_ALPHA_BETA_EN
    return ((ra > ia) ? ra : ia) + ((ra > ia) ? ia : ra) / 2;
`else
    return ra + ia;
`endif
  endfunction

  function automatic logic [N*MSB-1:0] mags_of(input logic [N*MSB-1:0] f);
    logic [N*MSB-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*MSB +: MSB] = 16'(mag_of(f[i*MSB +: MSB]));
    return r;
  endfunction

  function automatic int peak_bin_of(input logic [N*MSB-1:0] f);
    int best, bin;
    best = 0; bin = 0;
    for (int i = 0; i < N/2; i++) if (mag_of(f[i*MSB +: MSB]) > best) begin
      best = mag_of(f[i*MSB +: MSB]); bin = i;
    end
    return bin;
  endfunction

  function automatic int peak_mag_of(input logic [N*MSB-1:0] f);
    int best;
    best = 0;
    for (int i = 0; i < N/2; i++) if (mag_of(f[i*MSB +: MSB]) > best) best = mag_of(f[i*MSB +: MSB]);
    return best;
  endfunction

  function automatic logic [N*MSB-1:0] set_bin(input logic [N*MSB-1:0] f, input int i, input int re, input int im);
    logic [N*MSB-1:0] r;
    r = f;
    r[i*MSB +: MSB] = {8'(re), 8'(im)};
    return r;
  endfunction

  // Model: a frame is busy for N+2 edges after the accepted start edge, results appear with done.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  int               m_cnt  = 0;
  logic [N*MSB-1:0] m_frame = '0;
  logic [N*MSB-1:0] m_mag_bus = '0;
  int               m_pbin = 0;
  int               m_pmag = 0;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 0; m_mag_bus <= '0; m_pbin <= 0; m_pmag <= 0;
    end else if (!m_busy) begin
      if (ifc.start) begin
        m_busy <= 1'b1; m_cnt <= 1; m_frame <= ifc.data_bus;
      end
    end else if (m_cnt == N + 2) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b1;
      m_mag_bus <= mags_of(m_frame);
      m_pbin    <= peak_bin_of(m_frame);
      m_pmag    <= peak_mag_of(m_frame);
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", ifc.busy, m_busy);
    chk("done", ifc.done, m_done);
    if (!m_busy) begin
      chk("mag_bus", ifc.mag_bus, m_mag_bus);
      chk("peak_bin", ifc.peak_bin, m_pbin);
      chk("peak_mag", ifc.peak_mag, m_pmag);
    end
  end

  // mode 0: plain frame; 1: second start 10 cycles in; 2: one-cycle reset 15 cycles in.
  task automatic run_frame(input logic [N*MSB-1:0] f, input logic [N*MSB-1:0] alt, input int mode,
                           output int lat, output int busy_cnt, output int done_cnt);
    lat = 0; busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    ifc.data_bus = f;
    ifc.start    = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      rst       = 1'b0;
      if (mode == 1 && n == 10) begin ifc.data_bus = alt; ifc.start = 1'b1; end
      if (mode == 2 && n == 15) rst = 1'b1;
      if (ifc.done) begin
        done_cnt++;
        if (lat == 0) lat = n - 1;
      end
      if (ifc.busy) busy_cnt++;
    end
  endtask

  logic [N*MSB-1:0] f_zero, f_b5, f_tie, f_neg, f_alt;
  logic [15:0]      slot;
  int lat, bcnt, dcnt;

  initial begin
    rst = 1'b1; ifc.start = 1'b0; ifc.data_bus = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", ifc.busy, 1'b0);
    chk("reset_mag_bus", ifc.mag_bus, '0);
    rst = 1'b0;

    f_zero = '0;
    f_b5   = set_bin(f_zero, 5, 40, -30);
    f_tie  = set_bin(set_bin(set_bin(f_zero, 3, 20, 0), 9, 20, 0), 20, 100, 0);
    f_neg  = set_bin(f_zero, 1, -128, -128);
    f_alt  = set_bin(f_zero, 7, 120, 120);

    run_frame(f_zero, f_zero, 0, lat, bcnt, dcnt);
    chk("zero_latency", lat, 34);
    chk("zero_busy_cycles", bcnt, 34);
    chk("zero_done_count", dcnt, 1);
    chk("zero_peak_bin", ifc.peak_bin, 0);

    run_frame(f_b5, f_zero, 0, lat, bcnt, dcnt);
    slot = ifc.mag_bus[5*MSB +: MSB];
`ifdef FFT_MAG_ALPHA_BETA_EN
    chk("b5_slot", slot, 55);
    chk("b5_peak_mag", ifc.peak_mag, 55);
`else
    chk("b5_slot", slot, 70);
    chk("b5_peak_mag", ifc.peak_mag, 70);
`endif
    chk("b5_peak_bin", ifc.peak_bin, 5);
    chk("b5_latency", lat, 34);

    run_frame(f_tie, f_zero, 0, lat, bcnt, dcnt);
    slot = ifc.mag_bus[20*MSB +: MSB];
    chk("tie_slot20", slot, 100);
    chk("tie_peak_bin", ifc.peak_bin, 3);
    chk("tie_peak_mag", ifc.peak_mag, 20);

    run_frame(f_neg, f_zero, 0, lat, bcnt, dcnt);
    slot = ifc.mag_bus[1*MSB +: MSB];
`ifdef FFT_MAG_ALPHA_BETA_EN
    chk("neg_slot1", slot, 192);
    chk("neg_peak_mag", ifc.peak_mag, 192);
`else
    chk("neg_slot1", slot, 256);
    chk("neg_peak_mag", ifc.peak_mag, 256);
`endif

    run_frame(f_b5, f_alt, 1, lat, bcnt, dcnt);
    chk("ignore_done_count", dcnt, 1);
    chk("ignore_latency", lat, 34);
    chk("ignore_peak_bin", ifc.peak_bin, 5);

    run_frame(f_neg, f_zero, 2, lat, bcnt, dcnt);
    chk("rst_done_count", dcnt, 0);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_mag_bus", ifc.mag_bus, '0);
    chk("rst_peak_mag", ifc.peak_mag, 0);

    run_frame(f_tie, f_zero, 0, lat, bcnt, dcnt);
    chk("after_rst_latency", lat, 34);
    chk("after_rst_peak_bin", ifc.peak_bin, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_mag_peak.md
# fft_mag_peak

Post-FFT magnitude and peak-search stage for the 32-point FFT chain. It latches the complete spectrum bus when the FFT reports completion, then computes a per-bin magnitude one bin per clock through a 2-stage pipeline. It finds the strongest bin in the lower half-spectrum and emits a magnitude bus in the same packing as the FFT output, so the SPI output stage can consume either bus unchanged.

## Interface
- N, 32, FFT length (power of 2, ≥4); bins indexed 0..N-1
- MSB, 16, bits per bin slot; upper MSB/2 bits = signed real, lower MSB/2 bits = signed imag
- clk  in  1  system clock (16 MHz)
- rst  in  1  reset; synchronous, active-high
- start  in  1  single-cycle pulse, driven by FFT `fft_finish`
- data_bus  in  N*MSB  spectrum; bin i at data_bus[i*MSB +: MSB]
- busy  out  1  high from capture until done
- done  out  1  single-cycle pulse when all outputs are valid
- mag_bus  out  N*MSB  bin i magnitude at mag_bus[i*MSB +: MSB], zero-extended
- peak_bin  out  $clog2(N)  index of the largest magnitude in bins 0..N/2-1
- peak_mag  out  MSB/2+1  magnitude of peak_bin

## Operation
- States: IDLE, CALC, FLUSH.
- IDLE:
  - On start=1, capture data_bus into the frame register.
  - Clear the peak registers to 0.
  - Set idx=0 and busy=1, then go to CALC.
- CALC: each cycle, issue bin idx to stage 1 and increment idx. After issuing bin N-1, go to FLUSH.
- FLUSH: wait for the pipeline to drain, pulse done, return to IDLE with busy=0.
- Stage 1: ra=|re|, ia=|im|, each unsigned MSB/2 bits. The most negative value maps to 2^(MSB/2-1) with no saturation.
- Stage 2:
  - Compute mag with width MSB/2+1 and write it to slot idx of mag_bus.
  - If idx < N/2 and mag > peak_mag (strict), update peak_bin/peak_mag.
  - Ties keep the lower index. Bin 0 (DC) is included.
- mag_bus, peak_bin and peak_mag hold their values until the next capture. Slots for bins not yet processed keep the previous frame's values during busy.
- start while busy=1: ignored. No re-capture, no restart.
- data_bus changes after capture: no effect on the current frame.
- rst=1 at any time, including mid-frame:
  - State goes to IDLE.
  - busy=0 and done=0.
  - mag_bus, peak_bin and peak_mag are cleared to 0.
  - A pending frame is discarded.

## Timing
- Reset values: busy=0, done=0, mag_bus=0, peak_bin=0, peak_mag=0.
- Edge E0 samples start=1. Bin k is issued at edge E0+1+k and its magnitude is registered at E0+2+k.
- The last magnitude (bin N-1) is registered at E0+N+1.
- done is registered high at E0+N+2 and is high for exactly one cycle. busy falls on the same edge.
- For N=32, done is valid 34 clocks after the start edge.
- start arriving on the same edge that done falls is accepted, so back-to-back frames are possible.
- Combinational paths from input to output: none. All outputs are registered.

## Configuration
- FFT_MAG_ALPHA_BETA_EN defined: mag = max(ra,ia) + (min(ra,ia) >> 1). This alpha-max-beta-min approximation gives at most 3·2^(MSB/2-2).
- FFT_MAG_ALPHA_BETA_EN undefined: mag = ra + ia (L1 norm). This gives at most 2^(MSB/2).
- Latency, interface and widths are identical in both builds.

## Test plan
- All-zero frame, start pulse → done exactly 34 clocks later, mag_bus=0, peak_bin=0, peak_mag=0, busy high for 34 cycles.
- Bin 5 = (re=+40, im=-30), all other bins 0:
  - L1 build: slot 5 = 70, peak_bin=5, peak_mag=70.
  - Alpha-beta build: slot 5 = 55, peak_bin=5, peak_mag=55.
- Bin 3 and bin 9 both (re=20, im=0), bin 20 = (re=100, im=0) → peak_bin=3, peak_mag=20. Bin 20 is excluded from the search, but its mag_bus slot = 100.
- Bin 1 = (re=-128, im=-128):
  - L1 build: slot 1 = 256, peak_mag=256.
  - Alpha-beta build: slot 1 = 192, peak_mag=192.
- Second start pulse 10 cycles after the first, with a different data_bus → ignored. Results match the first frame and there is exactly one done pulse.
- rst asserted 15 cycles into a frame for 1 cycle → busy=0, done never pulses, all outputs 0. A new start afterwards completes normally in 34 cycles.
